id_stage_decoder: RTL
=====================

Name: id_stage_decoder

Overview:
- Registered RV32I instruction-decode pipeline stage, with optional M-extension decode.
- Sits between the IF/ID fetch output and the EX stage.
- Accepts one instruction per cycle over a valid/ready handshake and decodes it combinationally.
- Holds the decoded control bundle in an ID/EX output register.
- Inserts a load-use bubble on a hazard; supports a synchronous flush for taken branches and jumps.

Parameters:
- XLEN, 32, datapath width of PC, Imm and offset.
- ENABLE_M, 0, 1 enables decode of MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 flags them as illegal.
- ALUCODE_W, 5, width of ALUCode; must be at least 5 when ENABLE_M=1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  kill the instruction in the output register and the one offered on the input this cycle.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX consumes the output this cycle.
- out_pc  out  XLEN  registered PC.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_MemtoReg, out_RegWrite, out_MemWrite, out_MemRead, out_Jump, out_JALR, out_Branch, out_ALUSrcA  out  1 each  control signals.
- out_ALUSrcB  out  2  B-operand select.
- out_ALUCode  out  ALUCODE_W  ALU operation.
- out_Imm, out_offset  out  XLEN  immediate and branch/jump offset.
- out_illegal  out  1  unsupported opcode or funct combination.

Behaviour:
- Reset (rst_n=0 at an edge):
  - out_valid=0.
  - All registered outputs 0, including out_illegal.
  - in_ready=0 during the reset cycle.
- Decode table:
  - ALU codes 0–10: add, sub, lui, and, xor, or, sll, srl, sra, slt, sltu.
  - ENABLE_M=1 adds codes 11–18: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
  - SRAI (funct3=5, instr[30]=1) decodes to sra (8).
  - ORI (funct3=6) decodes to or (5).
- Immediates:
  - Imm and offset are never X. Any field not used by the opcode is driven to 0.
  - Shift-immediate Imm is {0, instr[24:20]}.
  - All other immediates are sign-extended to XLEN.
- Illegal instructions:
  - Trigger: unknown opcode, R-type with funct7 not in {0x00, 0x20, 0x01 when ENABLE_M}, or an SLLI/SRLI/SRAI with a nonzero funct7 other than 0x20 on a right shift.
  - Response: out_illegal=1 and RegWrite, MemWrite, MemRead, Jump, Branch all 0. The instruction still passes downstream.
- Control signal equations:
  - ALUSrcA = JAL | JALR | AUIPC.
  - ALUSrcB[1] = JAL | JALR.
  - ALUSrcB[0] = !(R-type | JAL | JALR | branch).
  - RegWrite is forced to 0 when rd=0.
- Load-use hazard:
  - hazard = out_valid & out_MemRead & (out_rd≠0) & in_valid & ((rs1_used & rs1==out_rd) | (rs2_used & rs2==out_rd)).
  - rs1_used covers R, I, load, store, branch and JALR.
  - rs2_used covers R, store and branch.
- Ready and accept:
  - in_ready = rst_n & !flush & !hazard & (!out_valid | out_ready).
  - accept = in_valid & in_ready.
- Register update priority, per edge:
  1. reset.
  2. flush → out_valid<=0.
  3. accept → load the decoded bundle, out_valid<=1.
  4. hazard & out_ready → out_valid<=0 (one bubble; the input is held by fetch).
  5. out_ready → out_valid<=0.
  6. Otherwise hold.
- Output stability: while out_valid & !out_ready, every out_* field is stable.
- Latency: 1 cycle from accept to out_valid; full throughput of 1 instruction per cycle with no hazard.
- Flush and accept in the same cycle is impossible, because in_ready=0 during flush.
- Reset mid-stream discards the held instruction. There is no deferred output.

Decomposition:
- Package riscv_dec_pkg holds:
  - opcode constants (R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - funct3/funct7 constants;
  - ALU code constants alu_add..alu_remu.
- Sub-module decode_comb is purely combinational: instruction → control bundle, imm/offset, illegal, rs*_used. It takes parameters XLEN and ENABLE_M.
- The top level owns the handshake, hazard detection and the output register.

Test Plan:
- Reset with rst_n=0 for 2 cycles, in_valid=1 → out_valid=0, in_ready=0; after release, in_ready=1.
- Stream 0x00500093 (addi x1,x0,5), then 0x4030D293 (srai x5,x1,3), with out_ready=1:
  - first instruction: out_ALUCode=0, out_Imm=5, RegWrite=1, out_valid one cycle after accept;
  - second instruction: out_ALUCode=8, out_Imm=3.
- Load-use: 0x0000A103 (lw x2,0(x1)), then 0x001101B3 (add x3,x2,x1):
  - in_ready=0 for exactly 1 cycle;
  - one out_valid=0 bubble;
  - then add issues with out_ALUCode=0.
- Back-pressure: hold out_ready=0 for 3 cycles with a valid output → in_ready=0 and outputs unchanged; on release, the next instruction loads the following cycle.
- Flush with out_valid=1 → next cycle out_valid=0; the instruction offered in the flush cycle is not accepted.
- Encoding 0x022081B3 (mul x3,x1,x2):
  - ENABLE_M=1 → out_ALUCode=11, out_illegal=0;
  - ENABLE_M=0 → out_illegal=1, RegWrite=0.
- Unknown opcode 0x0000007F → out_illegal=1 and all write/jump controls 0.

Source files
------------

// File: rtl/id_stage_decoder_pkg.sv
// Shared RV32I/M decode constants, control-bundle type and ALU-code helper
// for the ID stage.
package riscv_dec_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_LUI    = 5'd2;
    localparam logic [4:0] ALU_AND    = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_OR     = 5'd5;
    localparam logic [4:0] ALU_SLL    = 5'd6;
    localparam logic [4:0] ALU_SRL    = 5'd7;
    localparam logic [4:0] ALU_SRA    = 5'd8;
    localparam logic [4:0] ALU_SLT    = 5'd9;
    localparam logic [4:0] ALU_SLTU   = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd11;
    localparam logic [4:0] ALU_MULH   = 5'd12;
    localparam logic [4:0] ALU_MULHSU = 5'd13;
    localparam logic [4:0] ALU_MULHU  = 5'd14;
    localparam logic [4:0] ALU_DIV    = 5'd15;
    localparam logic [4:0] ALU_DIVU   = 5'd16;
    localparam logic [4:0] ALU_REM    = 5'd17;
    localparam logic [4:0] ALU_REMU   = 5'd18;

    typedef enum logic [3:0] {
        FMT_R, FMT_I, FMT_LOAD, FMT_STORE, FMT_BRANCH,
        FMT_JAL, FMT_JALR, FMT_LUI, FMT_AUIPC, FMT_BAD
    } fmt_e;

    typedef struct packed {
        logic       MemtoReg;
        logic       RegWrite;
        logic       MemWrite;
        logic       MemRead;
        logic       Jump;
        logic       JALR;
        logic       Branch;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [4:0] ALUCode;
    } ctrl_t;

    // alt selects SUB for funct3=0 and SRA for funct3=5; ignored elsewhere
    function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
        logic [4:0] code;
        case (f3)
            F3_ADD:  code = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  code = ALU_SLL;
            F3_SLT:  code = ALU_SLT;
            F3_SLTU: code = ALU_SLTU;
            F3_XOR:  code = ALU_XOR;
            F3_SR:   code = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/id_stage_decoder_if.sv
// Fetch-side and EX-side handshake/bundle signals of the ID stage.
interface id_stage_decoder_if #(
    parameter int XLEN      = 32,
    parameter int ALUCODE_W = 5
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic [XLEN-1:0]      in_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_pc;
    logic [4:0]           out_rs1;
    logic [4:0]           out_rs2;
    logic [4:0]           out_rd;
    logic                 out_MemtoReg;
    logic                 out_RegWrite;
    logic                 out_MemWrite;
    logic                 out_MemRead;
    logic                 out_Jump;
    logic                 out_JALR;
    logic                 out_Branch;
    logic                 out_ALUSrcA;
    logic [1:0]           out_ALUSrcB;
    logic [ALUCODE_W-1:0] out_ALUCode;
    logic [XLEN-1:0]      out_Imm;
    logic [XLEN-1:0]      out_offset;
    logic                 out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_MemtoReg, out_RegWrite, out_MemWrite, out_MemRead, out_Jump,
               out_JALR, out_Branch, out_ALUSrcA, out_ALUSrcB, out_ALUCode,
               out_Imm, out_offset, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_MemtoReg, out_RegWrite, out_MemWrite, out_MemRead, out_Jump,
               out_JALR, out_Branch, out_ALUSrcA, out_ALUSrcB, out_ALUCode,
               out_Imm, out_offset, out_illegal
    );
endinterface

// File: rtl/id_stage_decoder_decode_comb.sv
// Purely combinational RV32I(+M) decoder: instruction word to control bundle,
// immediate, branch/jump offset, illegal flag and source-register usage.
module decode_comb
    import riscv_dec_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0]     instr_i,
    output ctrl_t           ctrl_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] offset_o,
    output logic            illegal_o,
    output logic            rs1_used_o,
    output logic            rs2_used_o
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    fmt_e       fmt;

    logic signed [31:0] imm_i_s;
    logic signed [31:0] imm_s_s;
    logic signed [31:0] imm_b_s;
    logic signed [31:0] imm_j_s;
    logic signed [31:0] imm_u_s;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_i_s = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_s = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
    assign imm_j_s = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
    assign imm_u_s = {instr_i[31:12], 12'b0};

    always_comb begin
        case (opcode)
            OP_R:      fmt = FMT_R;
            OP_I:      fmt = FMT_I;
            OP_LOAD:   fmt = FMT_LOAD;
            OP_STORE:  fmt = FMT_STORE;
            OP_BRANCH: fmt = FMT_BRANCH;
            OP_JAL:    fmt = FMT_JAL;
            OP_JALR:   fmt = FMT_JALR;
            OP_LUI:    fmt = FMT_LUI;
            OP_AUIPC:  fmt = FMT_AUIPC;
            default:   fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        ctrl_o     = '0;
        imm_o      = '0;
        offset_o   = '0;
        illegal_o  = 1'b0;
        case (fmt)
            FMT_R: begin
                ctrl_o.RegWrite = 1'b1;
                if (ENABLE_M && funct7 == F7_MULDIV)
                    ctrl_o.ALUCode = ALU_MUL + {2'b00, funct3};
                else
                    ctrl_o.ALUCode = base_alu(funct3, funct7 == F7_ALT);
                illegal_o = !(funct7 == F7_BASE || funct7 == F7_ALT ||
                              (ENABLE_M && funct7 == F7_MULDIV));
            end
            FMT_I: begin
                ctrl_o.RegWrite = 1'b1;
                ctrl_o.ALUCode  = base_alu(funct3, funct3 == F3_SR && instr_i[30]);
                if (funct3 == F3_SLL || funct3 == F3_SR) begin
                    // shamt is unsigned; funct7 only carries the arithmetic-shift bit
                    imm_o     = XLEN'(instr_i[24:20]);
                    illegal_o = (funct3 == F3_SLL) ? (funct7 != F7_BASE)
                                                   : !(funct7 == F7_BASE || funct7 == F7_ALT);
                end else begin
                    imm_o = XLEN'(imm_i_s);
                end
            end
            FMT_LOAD: begin
                ctrl_o.MemtoReg = 1'b1;
                ctrl_o.RegWrite = 1'b1;
                ctrl_o.MemRead  = 1'b1;
                imm_o           = XLEN'(imm_i_s);
            end
            FMT_STORE: begin
                ctrl_o.MemWrite = 1'b1;
                imm_o           = XLEN'(imm_s_s);
            end
            FMT_BRANCH: begin
                ctrl_o.Branch = 1'b1;
                case (funct3)
                    F3_BLT, F3_BGE:   ctrl_o.ALUCode = ALU_SLT;
                    F3_BLTU, F3_BGEU: ctrl_o.ALUCode = ALU_SLTU;
                    default:          ctrl_o.ALUCode = ALU_SUB;
                endcase
                offset_o = XLEN'(imm_b_s);
            end
            FMT_JAL: begin
                ctrl_o.Jump     = 1'b1;
                ctrl_o.RegWrite = 1'b1;
                offset_o        = XLEN'(imm_j_s);
            end
            FMT_JALR: begin
                ctrl_o.JALR     = 1'b1;
                ctrl_o.RegWrite = 1'b1;
                offset_o        = XLEN'(imm_i_s);
            end
            FMT_LUI: begin
                ctrl_o.RegWrite = 1'b1;
                ctrl_o.ALUCode  = ALU_LUI;
                imm_o           = XLEN'(imm_u_s);
            end
            FMT_AUIPC: begin
                ctrl_o.RegWrite = 1'b1;
                imm_o           = XLEN'(imm_u_s);
            end
            default: illegal_o = 1'b1;
        endcase

        ctrl_o.ALUSrcA    = fmt inside {FMT_JAL, FMT_JALR, FMT_AUIPC};
        ctrl_o.ALUSrcB[1] = fmt inside {FMT_JAL, FMT_JALR};
        ctrl_o.ALUSrcB[0] = !(fmt inside {FMT_R, FMT_JAL, FMT_JALR, FMT_BRANCH});

        // an illegal instruction still flows downstream but must not change state
        if (illegal_o) begin
            ctrl_o.RegWrite = 1'b0;
            ctrl_o.MemWrite = 1'b0;
            ctrl_o.MemRead  = 1'b0;
            ctrl_o.Jump     = 1'b0;
            ctrl_o.Branch   = 1'b0;
        end
        if (rd == 5'd0)
            ctrl_o.RegWrite = 1'b0;
    end

    assign rs1_used_o = fmt inside {FMT_R, FMT_I, FMT_LOAD, FMT_STORE, FMT_BRANCH, FMT_JALR};
    assign rs2_used_o = fmt inside {FMT_R, FMT_STORE, FMT_BRANCH};

endmodule

// File: rtl/id_stage_decoder.sv
// RV32I ID stage: valid/ready handshake, load-use bubble, flush and the
// ID/EX output register around the combinational decoder.
module id_stage_decoder
    import riscv_dec_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit ENABLE_M  = 1'b0,
    parameter int ALUCODE_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    id_stage_decoder_if.slave bus
);

    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_offset;
    logic            dec_illegal;
    logic            dec_rs1_used;
    logic            dec_rs2_used;

    decode_comb #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .instr_i    (bus.in_instr),
        .ctrl_o     (dec_ctrl),
        .imm_o      (dec_imm),
        .offset_o   (dec_offset),
        .illegal_o  (dec_illegal),
        .rs1_used_o (dec_rs1_used),
        .rs2_used_o (dec_rs2_used)
    );

    logic            valid_q;
    logic            valid_d;
    ctrl_t           ctrl_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] offset_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    logic            illegal_q;

    logic [4:0] in_rs1;
    logic [4:0] in_rs2;
    logic       hazard;
    logic       accept;

    assign in_rs1 = bus.in_instr[19:15];
    assign in_rs2 = bus.in_instr[24:20];

    // a load still in ID/EX cannot forward to the instruction right behind it
    assign hazard = valid_q & ctrl_q.MemRead & (rd_q != 5'd0) & bus.in_valid &
                    ((dec_rs1_used & (in_rs1 == rd_q)) | (dec_rs2_used & (in_rs2 == rd_q)));

    assign bus.in_ready = rst_n & ~bus.flush & ~hazard & (~valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        valid_d = valid_q;
        if (bus.flush)
            valid_d = 1'b0;
        else if (accept)
            valid_d = 1'b1;
        else if (bus.out_ready)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc_q      <= '0;
            imm_q     <= '0;
            offset_q  <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                ctrl_q    <= dec_ctrl;
                pc_q      <= bus.in_pc;
                imm_q     <= dec_imm;
                offset_q  <= dec_offset;
                rs1_q     <= in_rs1;
                rs2_q     <= in_rs2;
                rd_q      <= bus.in_instr[11:7];
                illegal_q <= dec_illegal;
            end
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_pc       = pc_q;
    assign bus.out_rs1      = rs1_q;
    assign bus.out_rs2      = rs2_q;
    assign bus.out_rd       = rd_q;
    assign bus.out_MemtoReg = ctrl_q.MemtoReg;
    assign bus.out_RegWrite = ctrl_q.RegWrite;
    assign bus.out_MemWrite = ctrl_q.MemWrite;
    assign bus.out_MemRead  = ctrl_q.MemRead;
    assign bus.out_Jump     = ctrl_q.Jump;
    assign bus.out_JALR     = ctrl_q.JALR;
    assign bus.out_Branch   = ctrl_q.Branch;
    assign bus.out_ALUSrcA  = ctrl_q.ALUSrcA;
    assign bus.out_ALUSrcB  = ctrl_q.ALUSrcB;
    assign bus.out_ALUCode  = ALUCODE_W'(ctrl_q.ALUCode);
    assign bus.out_Imm      = imm_q;
    assign bus.out_offset   = offset_q;
    assign bus.out_illegal  = illegal_q;

endmodule
